// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter that merges several SPI word streams onto one transmitter.
// A grant is held for one frame, a burst limit, or until the owner goes idle.
module spi_tx_arbiter #(
  parameter int p_data_width   = 8,
  parameter int p_num_req      = 4,
  parameter int p_max_burst    = 4,
  parameter int p_idle_timeout = 16
) (
  input  logic                              clk,
  input  logic                              a_rst,
  input  logic [p_num_req-1:0]              req_valid,
  input  logic [p_num_req*p_data_width-1:0] req_data,
  input  logic [p_num_req-1:0]              req_last,
  output logic [p_num_req-1:0]              req_ready,
  output logic                              tx_valid,
  output logic [p_data_width-1:0]           tx_data,
  input  logic                              tx_ready,
  output logic [p_num_req-1:0]              grant,
  output logic                              busy
);

  localparam int IW = $clog2(p_num_req);
  localparam int BW = $clog2(p_max_burst + 1);
  localparam int TW = $clog2(p_idle_timeout + 1);
  localparam logic [BW-1:0] MAXB = BW'(p_max_burst);
  localparam logic [TW-1:0] TOUT = TW'(p_idle_timeout);
  localparam logic [IW-1:0] LASTIDX = IW'(p_num_req - 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  state_t               state;
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        g_idx;
  logic [p_num_req-1:0] grant_q;
  logic                 busy_q;
  logic [BW-1:0]        beat_cnt;
  logic [TW-1:0]        to_cnt;

  logic                 pick_found;
  logic [IW-1:0]        pick_idx;
  logic [p_num_req-1:0] pick_oh;
  logic                 sel_valid;
  logic                 sel_last;
  logic                 in_grant;
  logic                 beat;
  logic [BW-1:0]        beat_nxt;
  logic [TW-1:0]        to_nxt;
  logic [IW-1:0]        rr_nxt;

  // First requesting index at or above rr_ptr, wrapping around.
  always_comb begin : pick_blk
    int j;
    j          = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_oh    = '0;
    for (int k = 0; k < p_num_req; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= p_num_req) j = j - p_num_req;
      if (!pick_found && req_valid[j]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(j);
        pick_oh[j] = 1'b1;
      end
    end
  end

  assign in_grant  = (state == GRANT);
  assign sel_valid = |(req_valid & grant_q);
  assign sel_last  = |(req_last & grant_q);
  assign tx_valid  = in_grant & sel_valid;
  assign beat      = tx_valid & tx_ready;
  assign beat_nxt  = beat_cnt + BW'(1);
  assign to_nxt    = to_cnt + TW'(1);
  assign rr_nxt    = (g_idx == LASTIDX) ? '0 : g_idx + IW'(1);

  always_comb begin
    tx_data   = '0;
    req_ready = '0;
    if (in_grant) begin
      req_ready = grant_q & {p_num_req{tx_ready}};
      for (int i = 0; i < p_num_req; i++) begin
        if (grant_q[i]) tx_data = req_data[i*p_data_width +: p_data_width];
      end
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      g_idx    <= '0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
      beat_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          beat_cnt <= '0;
          to_cnt   <= '0;
          if (pick_found) begin
            state   <= GRANT;
            grant_q <= pick_oh;
            g_idx   <= pick_idx;
            busy_q  <= 1'b1;
          end
        end
        GRANT: begin
          if (beat) begin
            beat_cnt <= beat_nxt;
            to_cnt   <= '0;
            if (sel_last || (beat_nxt == MAXB)) begin
              state   <= GAP;
              grant_q <= '0;
              rr_ptr  <= rr_nxt;
            end
          end else if (!sel_valid) begin
            to_cnt <= to_nxt;
            if (to_nxt == TOUT) begin
              state   <= GAP;
              grant_q <= '0;
              rr_ptr  <= rr_nxt;
            end
          end
        end
        GAP: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/spi_tx_arbiter.md
SPI_TX_ARBITER -- requirements
Module: spi_tx_arbiter

Interface
REQ-001 Parameter p_data_width, default 8, width of one SPI word.
REQ-002 Parameter p_num_req, default 4, number of requesters (2..8).
REQ-003 Parameter p_max_burst, default 4, maximum words per grant (1..255).
REQ-004 Parameter p_idle_timeout, default 16, cycles without req_valid before a held grant is released (1..255).
REQ-005 clk  input  1  system clock; all state on rising edge.
REQ-006 a_rst  input  1  asynchronous reset, active-high.
REQ-007 req_valid  input  p_num_req  per-requester word valid.
REQ-008 req_data  input  p_num_req*p_data_width  per-requester word; requester i occupies bits [i*p_data_width +: p_data_width].
REQ-009 req_last  input  p_num_req  per-requester last-word-of-frame flag, qualified by req_valid.
REQ-010 req_ready  output  p_num_req  per-requester accept.
REQ-011 tx_valid  output  1  word valid to transmitter.
REQ-012 tx_data  output  p_data_width  word to transmitter.
REQ-013 tx_ready  input  1  transmitter accept.
REQ-014 grant  output  p_num_req  one-hot current owner; all-zero when not granted.
REQ-015 busy  output  1  high in GRANT and GAP.

Function
REQ-016 FSM states IDLE, GRANT, GAP; encoding free.
REQ-017 IDLE: if any req_valid bit is set, select the first set bit searching upward from rr_ptr with wrap-around; register grant and enter GRANT next cycle; beat and timeout counters cleared.
REQ-018 IDLE with no req_valid: remain in IDLE; grant=0, tx_valid=0, req_ready=0.
REQ-019 GRANT: tx_valid=req_valid[g], tx_data=req_data[g], req_ready[g]=tx_ready, all other req_ready bits 0 (combinational pass-through, zero added latency).
REQ-020 Beat = tx_valid & tx_ready in GRANT; each beat increments beat counter and clears timeout counter.
REQ-021 GRANT -> GAP on a beat with req_last[g]=1, or on the beat that makes beat count equal p_max_burst, whichever first.
REQ-022 GRANT with req_valid[g]=0: timeout counter increments each cycle; on reaching p_idle_timeout, GRANT -> GAP without a beat.
REQ-023 GAP lasts exactly one cycle; grant=0, tx_valid=0, req_ready=0; then IDLE.
REQ-024 On leaving GRANT, rr_ptr = (g+1) mod p_num_req; rr_ptr unchanged otherwise.
REQ-025 Non-granted requesters' valid changes have no effect during GRANT and GAP.
REQ-026 tx_valid never asserts outside GRANT; no word is dropped or duplicated: each accepted word yields exactly one req_ready&req_valid handshake.
REQ-027 Minimum re-arbitration cost: one GAP plus one IDLE cycle between grants (lets the transmitter deassert cs_n between frames).
REQ-028 Beat and timeout counters sized ceil(log2(max+1)); no wrap occurs because exit precedes overflow.

Reset
REQ-029 a_rst asserted: immediately state=IDLE, rr_ptr=0, counters=0, grant=0, busy=0, tx_valid=0, req_ready=0, independent of clk.
REQ-030 a_rst mid-burst discards the in-flight grant; the first cycle after release is IDLE and arbitration restarts from requester 0.

Verification
REQ-031 Single requester 2, 3 words, last on word 3, tx_ready=1 -> grant=0100 for 3 beats, GAP one cycle, rr_ptr=3, tx_data matches req_data[2] in order.
REQ-032 All four valid continuously, each frame 1 word with last -> grant sequence 0001,0010,0100,1000,0001, each separated by GAP+IDLE.
REQ-033 Requester 0 streams 10 words without last, p_max_burst=4 -> grants of 4,4,2 words, requester 1 (also valid) served between bursts.
REQ-034 Requester 1 granted, drops valid after 1 word -> release after exactly 16 idle cycles, GAP, then IDLE.
REQ-035 tx_ready held low 5 cycles mid-burst -> tx_valid stays high, tx_data stable, no req_ready, beat count unchanged.
REQ-036 a_rst pulsed mid-burst asynchronously (between edges) -> outputs zero before next edge; after release requester 0 wins if valid.
